// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam int          DM_ADDR_W_DEFAULT = 12;
  localparam logic [31:0] DM_BASE_DEFAULT   = 32'h0000_0000;
  localparam int          DM_WORDS          = 1 << DM_ADDR_W_DEFAULT;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational picker; prio names the winner when both request.
// DM_ARB_CPU_PRIO_EN: fixed priority, CPU port wins every contest and prio is ignored.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       sel
);

`ifdef DM_ARB_CPU_PRIO_EN
  logic unused_prio;
  assign unused_prio = prio;

  always_comb begin
    sel = PORT_CPU;
    if (req == 2'b10) sel = PORT_DMA;
  end
`else
  always_comb begin
    sel = prio;
    case (req)
      2'b01:   sel = PORT_CPU;
      2'b10:   sel = PORT_DMA;
      default: sel = prio;
    endcase
  end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port DM between the CPU M-stage (port 0) and the DMA engine (port 1).
// DM_ARB_CPU_PRIO_EN selects fixed CPU priority instead of round-robin.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int          ADDR_W  = DM_ADDR_W_DEFAULT,
  parameter logic [31:0] DM_BASE = DM_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [3:0]        be0,
  input  logic [3:0]        be1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t state, state_nx;
  logic   sel, pick, prio, ok;
  logic   we_sel, in_range;
  logic [31:0] addr_sel, off;

  rr_arb2 u_pick (
    .req  ({req1, req0}),
    .prio (prio),
    .sel  (pick)
  );

  assign we_sel   = sel ? we1   : we0;
  assign addr_sel = sel ? addr1 : addr0;
  assign off      = addr_sel - DM_BASE;
  // Anything above the word-index field is outside the array.
  assign in_range = (off >> (ADDR_W + 2)) == 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= PORT_CPU;
      ok    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (req0 || req1)) sel <= pick;
      if (state == ISSUE) ok <= in_range;
    end
  end

`ifdef DM_ARB_CPU_PRIO_EN
  assign prio = PORT_CPU;
`else
  always_ff @(posedge clk) begin
    if (reset) prio <= PORT_CPU;
    else if (state == IDLE && (req0 || req1)) prio <= ~pick;
  end
`endif

  always_comb begin
    state_nx  = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    rdata     = 32'd0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        if (req0 || req1) state_nx = ISSUE;
      end
      ISSUE: begin
        state_nx  = RESP;
        mem_en    = in_range;
        mem_we    = we_sel & in_range;
        mem_addr  = off[ADDR_W+1:2];
        mem_be    = sel ? be1 : be0;
        mem_wdata = sel ? wdata1 : wdata0;
      end
      RESP: begin
        state_nx = IDLE;
        ack0     = ~sel;
        ack1     = sel;
        err0     = ~sel & ~ok;
        err1     = sel & ~ok;
        if (ok && !we_sel) rdata = mem_rdata;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: behavioural DM, transaction-level reference model, randomized traffic.
module tb_dm_arbiter;

  typedef struct {
    bit          v;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;

  logic        clk, reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  dm_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .err0      (err0),
    .err1      (err1),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Behavioural single-port DM; contents reload to a known pattern on reset.
  logic [31:0] dm [4096];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) dm[i] <= pat(i);
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) dm[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= dm[mem_addr];
    end
  end

  // Reference model: word array plus "last granted port loses the next contest".
  logic [31:0] ref_mem [4096];
  int tb_prio;

  task automatic ref_reset();
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    tb_prio = 0;
  endtask

  function automatic bit in_rng(logic [31:0] a);
    return (longint'(a) / 4) < 4096;
  endfunction

  function automatic logic [31:0] model_access(txn_t t);
    int idx;
    logic [31:0] w;
    if (!in_rng(t.addr)) return 32'd0;
    idx = int'(t.addr / 4);
    if (!t.we) return ref_mem[idx];
    w = ref_mem[idx];
    for (int b = 0; b < 4; b++)
      if (t.be[b]) w[b*8 +: 8] = t.wd[b*8 +: 8];
    ref_mem[idx] = w;
    return 32'd0;
  endfunction

  function automatic int model_grant(bit v0, bit v1);
    int w;
    if (v0 && v1) begin
`ifdef DM_ARB_CPU_PRIO_EN
      w = 0;
`else
      w = tb_prio;
`endif
    end else begin
      w = v1 ? 1 : 0;
    end
    tb_prio = 1 - w;
    return w;
  endfunction

  function automatic txn_t mk(bit v, bit we, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    txn_t t;
    t.v = v; t.we = we; t.addr = a; t.be = be; t.wd = wd;
    return t;
  endfunction

  int          exp_cyc [2];
  logic [31:0] exp_rd  [2];
  logic        exp_err [2];
  int          obs_cyc [2];
  logic [31:0] obs_rd  [2];
  logic        obs_err [2];
  logic        obs_men [2];
  logic        obs_mwe [2];
  logic [11:0] obs_maddr [2];
  logic [3:0]  obs_mbe [2];
  logic [31:0] obs_mwd [2];
  int          obs_spur;

  // Drives one or two requests from a negedge and records what comes back over 8 cycles.
  task automatic run_pair(input txn_t t0, input txn_t t1);
    int f, s;
    bit act [2];
    logic        p_en, p_we;
    logic [11:0] p_addr;
    logic [3:0]  p_be;
    logic [31:0] p_wd;
    exp_cyc[0] = -1; exp_cyc[1] = -1;
    exp_rd[0] = 0; exp_rd[1] = 0;
    exp_err[0] = 0; exp_err[1] = 0;
    f = model_grant(t0.v, t1.v);
    exp_cyc[f] = 2;
    exp_err[f] = !in_rng(f == 1 ? t1.addr : t0.addr);
    exp_rd[f]  = model_access(f == 1 ? t1 : t0);
    if (t0.v && t1.v) begin
      s = 1 - f;
      void'(model_grant(s == 0, s == 1));
      exp_cyc[s] = 5;
      exp_err[s] = !in_rng(s == 1 ? t1.addr : t0.addr);
      exp_rd[s]  = model_access(s == 1 ? t1 : t0);
    end
    for (int p = 0; p < 2; p++) begin
      obs_cyc[p] = -1; obs_rd[p] = 'x; obs_err[p] = 1'bx;
      obs_men[p] = 1'bx; obs_mwe[p] = 1'bx; obs_maddr[p] = 'x; obs_mbe[p] = 'x; obs_mwd[p] = 'x;
    end
    obs_spur = 0;
    act[0] = t0.v; act[1] = t1.v;
    req0 = t0.v; we0 = t0.we; addr0 = t0.addr; be0 = t0.be; wdata0 = t0.wd;
    req1 = t1.v; we1 = t1.we; addr1 = t1.addr; be1 = t1.be; wdata1 = t1.wd;
    p_en = mem_en; p_we = mem_we; p_addr = mem_addr; p_be = mem_be; p_wd = mem_wdata;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack0 && ack1) obs_spur++;
      if (!ack0 && !ack1 && (rdata !== 32'd0 || err0 || err1)) obs_spur++;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? ack0 : ack1) begin
          if (!act[p]) obs_spur++;
          else begin
            obs_cyc[p] = k; obs_rd[p] = rdata; obs_err[p] = (p == 0) ? err0 : err1;
            obs_men[p] = p_en; obs_mwe[p] = p_we; obs_maddr[p] = p_addr;
            obs_mbe[p] = p_be; obs_mwd[p] = p_wd;
            act[p] = 0;
            if (p == 0) req0 = 1'b0; else req1 = 1'b0;
          end
        end
      end
      p_en = mem_en; p_we = mem_we; p_addr = mem_addr; p_be = mem_be; p_wd = mem_wdata;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ack0, ack1, err0, err1, rdata, mem_en, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ack=%b%b err=%b%b rdata=%h mem_en=%b mem_we=%b, expected all zero",
               ack0, ack1, err0, err1, rdata, mem_en, mem_we);
    end
    reset = 1'b0;
    ref_reset();
  endtask

  task automatic test_cpu_write();
    run_pair(mk(1, 1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF), mk(0, 0, 0, 0, 0));
    vectors++;
    if (obs_cyc[0] !== 2) begin miscompares++; $display("FAIL wr_ack_cycle: got %0d expected 2", obs_cyc[0]); end
    vectors++;
    if ({obs_men[0], obs_mwe[0]} !== 2'b11) begin miscompares++; $display("FAIL wr_mem_en_we: got %b%b expected 11", obs_men[0], obs_mwe[0]); end
    vectors++;
    if (obs_maddr[0] !== 12'd4) begin miscompares++; $display("FAIL wr_mem_addr: got %0d expected 4", obs_maddr[0]); end
    vectors++;
    if (obs_mbe[0] !== 4'hF || obs_mwd[0] !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL wr_mem_data: got be=%h wdata=%h expected be=f wdata=deadbeef", obs_mbe[0], obs_mwd[0]);
    end
    vectors++;
    if (obs_err[0] !== 1'b0 || obs_cyc[1] !== -1 || obs_spur !== 0) begin
      miscompares++; $display("FAIL wr_err_spur: got err0=%b ack1_cyc=%0d spurious=%0d expected 0,-1,0", obs_err[0], obs_cyc[1], obs_spur);
    end
  endtask

  task automatic test_readback();
    run_pair(mk(1, 0, 32'h0000_0010, 4'h0, 32'h0), mk(0, 0, 0, 0, 0));
    vectors++;
    if (obs_rd[0] !== 32'hDEAD_BEEF || obs_cyc[0] !== 2) begin
      miscompares++; $display("FAIL readback: got rdata=%h cyc=%0d expected deadbeef at 2", obs_rd[0], obs_cyc[0]);
    end
    run_pair(mk(1, 1, 32'h0000_0010, 4'h2, 32'h0000_5500), mk(0, 0, 0, 0, 0));
    run_pair(mk(1, 0, 32'h0000_0011, 4'h0, 32'h0), mk(0, 0, 0, 0, 0));
    vectors++;
    if (obs_rd[0] !== 32'hDEAD_55EF) begin
      miscompares++; $display("FAIL byte_write_readback: got %h expected dead55ef", obs_rd[0]);
    end
  endtask

  task automatic test_out_of_range();
    run_pair(mk(0, 0, 0, 0, 0), mk(1, 0, 32'h0000_4000, 4'h0, 32'h0));
    vectors++;
    if (obs_men[1] !== 1'b0 || obs_err[1] !== 1'b1 || obs_rd[1] !== 32'd0 || obs_cyc[1] !== 2) begin
      miscompares++;
      $display("FAIL oor_read: got mem_en=%b err1=%b rdata=%h cyc=%0d expected 0,1,0,2", obs_men[1], obs_err[1], obs_rd[1], obs_cyc[1]);
    end
    run_pair(mk(0, 0, 0, 0, 0), mk(1, 1, 32'h0000_4010, 4'hF, 32'h0BAD_F00D));
    vectors++;
    if (obs_men[1] !== 1'b0 || obs_mwe[1] !== 1'b0 || obs_err[1] !== 1'b1) begin
      miscompares++; $display("FAIL oor_write: got mem_en=%b mem_we=%b err1=%b expected 0,0,1", obs_men[1], obs_mwe[1], obs_err[1]);
    end
    run_pair(mk(1, 0, 32'h0000_0010, 4'h0, 32'h0), mk(0, 0, 0, 0, 0));
    vectors++;
    if (obs_rd[0] !== 32'hDEAD_55EF) begin
      miscompares++; $display("FAIL oor_dm_unchanged: got %h expected dead55ef", obs_rd[0]);
    end
  endtask

  task automatic test_contention();
    int acks, last, p, w;
    logic [31:0] e;
    txn_t ta, tb;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_reset();
    run_pair(mk(1, 0, 32'h0000_0100, 4'h0, 32'h0), mk(1, 0, 32'h0000_0200, 4'h0, 32'h0));
    vectors++;
    if (obs_cyc[0] !== 2 || obs_cyc[1] !== 5) begin
      miscompares++; $display("FAIL contention_timing: got ack0@%0d ack1@%0d expected 2 and 5", obs_cyc[0], obs_cyc[1]);
    end
    vectors++;
    if (obs_rd[0] !== exp_rd[0] || obs_rd[1] !== exp_rd[1]) begin
      miscompares++; $display("FAIL contention_data: got %h/%h expected %h/%h", obs_rd[0], obs_rd[1], exp_rd[0], exp_rd[1]);
    end
    // Both held: grants alternate under round-robin, CPU every time under fixed priority.
    ta = mk(1, 0, 32'h0000_0300, 4'h0, 32'h0);
    tb = mk(1, 0, 32'h0000_0304, 4'h0, 32'h0);
    req0 = 1'b1; we0 = 1'b0; addr0 = ta.addr; be0 = 4'h0; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = tb.addr; be1 = 4'h0; wdata1 = 32'h0;
    acks = 0; last = -1;
    for (int k = 1; k <= 40 && acks < 8; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        w = model_grant(1, 1);
        e = model_access(w == 1 ? tb : ta);
        vectors++;
        if (p !== w || (ack0 && ack1)) begin
          miscompares++; $display("FAIL held_grant_%0d: got port %0d expected port %0d", acks, p, w);
        end
        vectors++;
        if (k - last !== ((last < 0) ? k + 1 : 3) || rdata !== e) begin
          miscompares++; $display("FAIL held_spacing_%0d: got cycle %0d rdata %h expected gap 3 rdata %h", acks, k, rdata, e);
        end
        last = k;
        acks++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (acks !== 8) begin miscompares++; $display("FAIL held_ack_count: got %0d expected 8", acks); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acks, c0, c1, extra;
    logic [31:0] r0, r1, e0, e1;
    txn_t t;
    t = mk(1, 0, 32'h0000_0040, 4'h0, 32'h0);
    req0 = 1'b1; we0 = 1'b0; addr0 = t.addr; be0 = 4'h0; wdata0 = 32'h0;
    acks = 0; c0 = -1; c1 = -1; extra = 0; r0 = 0; r1 = 0;
    void'(model_grant(1, 0)); e0 = model_access(t);
    void'(model_grant(1, 0)); e1 = model_access(t);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ack1) extra++;
      if (ack0) begin
        if (acks == 0) begin c0 = k; r0 = rdata; end
        else if (acks == 1) begin c1 = k; r1 = rdata; end
        else extra++;
        acks++;
        if (acks == 2) req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    vectors++;
    if (c0 !== 2 || c1 !== 5) begin miscompares++; $display("FAIL b2b_ack_cycles: got %0d,%0d expected 2,5", c0, c1); end
    vectors++;
    if (acks !== 2 || extra !== 0) begin miscompares++; $display("FAIL b2b_ack_count: got %0d acks %0d extra expected 2,0", acks, extra); end
    vectors++;
    if (r0 !== e0 || r1 !== e1) begin miscompares++; $display("FAIL b2b_data: got %h,%h expected %h,%h", r0, r1, e0, e1); end
  endtask

  task automatic test_reset_issue();
    int stray;
    run_pair(mk(1, 0, 32'h0000_0008, 4'h0, 32'h0), mk(0, 0, 0, 0, 0));
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0020; be0 = 4'h0; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0030; be1 = 4'h0; wdata1 = 32'h0;
    @(negedge clk);
    vectors++;
`ifdef DM_ARB_CPU_PRIO_EN
    if (mem_en !== 1'b1 || mem_addr !== 12'd8) begin
      miscompares++; $display("FAIL rst_issue_pre: got mem_en=%b mem_addr=%0d expected 1,8", mem_en, mem_addr);
    end
`else
    if (mem_en !== 1'b1 || mem_addr !== 12'd12) begin
      miscompares++; $display("FAIL rst_issue_pre: got mem_en=%b mem_addr=%0d expected 1,12", mem_en, mem_addr);
    end
`endif
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, err0, err1, rdata, mem_en, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      miscompares++; $display("FAIL rst_issue_outputs: got ack=%b%b mem_en=%b rdata=%h expected all zero", ack0, ack1, mem_en, rdata);
    end
    reset = 1'b0;
    ref_reset();
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1 || mem_en) stray++;
    end
    vectors++;
    if (stray !== 0) begin miscompares++; $display("FAIL rst_issue_no_ack: got %0d active cycles expected 0", stray); end
    run_pair(mk(1, 0, 32'h0000_0020, 4'h0, 32'h0), mk(1, 0, 32'h0000_0030, 4'h0, 32'h0));
    vectors++;
    if (obs_cyc[0] !== 2 || obs_cyc[1] !== 5) begin
      miscompares++; $display("FAIL rst_issue_regrant: got ack0@%0d ack1@%0d expected 2 and 5", obs_cyc[0], obs_cyc[1]);
    end
  endtask

  task automatic test_random();
    txn_t t[2];
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < 2; p++) begin
        t[p].v  = 1'($urandom_range(0, 1));
        t[p].we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) t[p].addr = $urandom | 32'h0000_4000;
        else t[p].addr = 32'($urandom_range(0, 16383));
        t[p].be = 4'($urandom);
        t[p].wd = $urandom;
      end
      if (!t[0].v && !t[1].v) t[0].v = 1'b1;
      run_pair(t[0], t[1]);
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (obs_cyc[p] !== exp_cyc[p]) begin
          miscompares++; $display("FAIL rnd%0d_cyc_p%0d: got %0d expected %0d", n, p, obs_cyc[p], exp_cyc[p]);
        end
        if (t[p].v) begin
          vectors++;
          if (obs_rd[p] !== exp_rd[p] || obs_err[p] !== exp_err[p]) begin
            miscompares++;
            $display("FAIL rnd%0d_resp_p%0d: got rdata=%h err=%b expected rdata=%h err=%b", n, p, obs_rd[p], obs_err[p], exp_rd[p], exp_err[p]);
          end
        end
      end
      vectors++;
      if (obs_spur !== 0) begin miscompares++; $display("FAIL rnd%0d_spurious: got %0d expected 0", n, obs_spur); end
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; be0 = 4'd0; be1 = 4'd0;
    wdata0 = 32'd0; wdata1 = 32'd0;
    tb_prio = 0;
    test_reset();
    test_cpu_write();
    test_readback();
    test_out_of_range();
    test_contention();
    test_back_to_back();
    test_reset_issue();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
